// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg
//   Shared definitions for the multiplier arbiter and its round-robin picker:
//   FSM state encoding, default parameter values and width helpers.
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 63;
    localparam int DEF_CNT_W   = $clog2(DEF_TIMEOUT + 1);

    // Width of the WAIT-state watchdog counter; it must be able to hold TIMEOUT.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // Width of a requester index.
    function automatic int idx_width(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin priority encoder. Searches req starting at
//   last+1 and wrapping modulo N_REQ; the first set bit wins.
//   Ports:
//     req    in  N_REQ  request vector
//     last   in  IW     index served most recently
//     any    out 1      at least one request is pending
//     winner out IW     selected index (0 when any is low)
module rr_picker
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             any,
    output logic [IW-1:0]    winner
);

    logic          found;
    int            pos;
    logic [IW-1:0] sel;

    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        sel    = '0;
        // k = N_REQ lands back on last itself, so it has the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(last) + k) % N_REQ;
            sel = IW'(pos);
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin arbiter and sequencer for a shared 8x8 sequential multiplier.
//   One requester is granted at a time; its operands are loaded into the
//   multiplier, the block waits for the ready pulse (bounded by a watchdog)
//   and returns the 16-bit product with a one-cycle done strobe.
//
//   Handshake: a requester raises req[i] with op_a/op_b slice i stable and
//   keeps it up until done[i]; operands are sampled once in IDLE. done[i] is
//   a single-cycle strobe with res/err valid in that cycle only, and the
//   requester drops req[i] in that cycle (a req still high in the following
//   IDLE cycle is arbitrated as a new request). The multiplier side gets a
//   one-cycle mult_ld with mult_a/mult_b held until DONE and answers with a
//   one-cycle mult_rdy, honoured only in WAIT.
//
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous active-low reset
//     req          in   N_REQ  per-requester request level
//     op_a, op_b   in   8*N_REQ packed operands, requester i at [8i+7:8i]
//     gnt          out  N_REQ  one-hot grant, LOAD through DONE
//     done         out  N_REQ  one-hot completion strobe
//     res          out  16     product (0 on timeout)
//     err          out  1      timeout flag, valid with done
//     busy         out  1      FSM not in IDLE
//     mult_ld      out  1      multiplier load strobe
//     mult_a/b     out  8      registered multiplier operands
//     mult_rdy     in   1      multiplier ready pulse
//     mult_result  in   16     multiplier product
//     state_dbg    out  2      current FSM state (state_t encoding)
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] op_a,
    input  logic [8*N_REQ-1:0] op_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [15:0]        res,
    output logic               err,
    output logic               busy,
    output logic               mult_ld,
    output logic [7:0]         mult_a,
    output logic [7:0]         mult_b,
    input  logic               mult_rdy,
    input  logic [15:0]        mult_result,
    output logic [1:0]         state_dbg
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t           state, state_next;
    logic [IW-1:0]    idx, idx_next;
    logic [IW-1:0]    last, last_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [7:0]       a_next, b_next;
    logic [15:0]      res_next;
    logic             err_next;
    logic [N_REQ-1:0] gnt_next, done_next;
    logic             busy_next, ld_next;

    logic             pick_any;
    logic [IW-1:0]    pick;
    logic [IW+2:0]    pick_base;

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req    (req),
        .last   (last),
        .any    (pick_any),
        .winner (pick)
    );

    assign pick_base = {pick, 3'b000};
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        last_next  = last;
        cnt_next   = cnt;
        a_next     = mult_a;
        b_next     = mult_b;
        res_next   = '0;
        err_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    idx_next   = pick;
                    a_next     = op_a[pick_base +: 8];
                    b_next     = op_b[pick_base +: 8];
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A ready pulse in the same cycle as the timeout still wins.
                if (mult_rdy) begin
                    res_next   = mult_result;
                    state_next = ST_DONE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_DONE: begin
                last_next  = idx;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ld_next   = (state_next == ST_LOAD);
        busy_next = (state_next != ST_IDLE);
        gnt_next  = busy_next ? (ONE << idx_next) : '0;
        done_next = (state_next == ST_DONE) ? (ONE << idx_next) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            last    <= IW'(N_REQ - 1);
            cnt     <= '0;
            mult_a  <= '0;
            mult_b  <= '0;
            res     <= '0;
            err     <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            mult_ld <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            last    <= last_next;
            cnt     <= cnt_next;
            mult_a  <= a_next;
            mult_b  <= b_next;
            res     <= res_next;
            err     <= err_next;
            gnt     <= gnt_next;
            done    <= done_next;
            busy    <= busy_next;
            mult_ld <= ld_next;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int TO = 63;
    localparam int EW = N + 17;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] op_a, op_b;
    logic [N-1:0]   gnt, done;
    logic [15:0]    res;
    logic           err, busy, mult_ld;
    logic [7:0]     mult_a, mult_b;
    logic           mult_rdy;
    logic [15:0]    mult_result;
    logic [1:0]     state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // expected {done vector, res, err} per completion
    logic [EW-1:0] exp_q[$];

    // multiplier model controls
    int          mult_lat  = 4;
    bit          mult_mute = 1'b0;
    bit          mult_rand = 1'b0;
    bit          force_en  = 1'b0;
    logic [15:0] force_val = '0;
    int          m_cnt     = 0;
    bit          m_pend    = 1'b0;
    logic [15:0] m_prod    = '0;
    int          rdy_seen  = 0;

    mult_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .gnt         (gnt),
        .done        (done),
        .res         (res),
        .err         (err),
        .busy        (busy),
        .mult_ld     (mult_ld),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_rdy    (mult_rdy),
        .mult_result (mult_result),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- multiplier model ----------------
    // Raises mult_rdy for one cycle mult_lat cycles after the LOAD cycle.
    initial begin
        mult_rdy    = 1'b0;
        mult_result = '0;
        forever begin
            @(negedge clk);
            mult_rdy = 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    mult_rdy    = 1'b1;
                    mult_result = force_en ? force_val : m_prod;
                    m_pend      = 1'b0;
                    rdy_seen++;
                end else begin
                    m_cnt--;
                end
            end
            if (mult_ld === 1'b1 && !mult_mute) begin
                m_pend = 1'b1;
                m_cnt  = (mult_rand ? int'($urandom_range(1, 6)) : mult_lat) - 1;
                m_prod = {8'h00, mult_a} * {8'h00, mult_b};
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[8*i +: 8] = a;
        op_b[8*i +: 8] = b;
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] d, output logic [15:0] r,
                             output logic e, output int at);
        bit seen;
        seen = 1'b0;
        d = '0; r = '0; e = 1'b0; at = -1;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done !== '0) begin
                d = done; r = res; e = err; at = cyc; seen = 1'b1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [EW-1:0] unused;
        req = '0; op_a = '0; op_b = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({gnt, done, res, err, busy, mult_ld, mult_a, mult_b} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {gnt, done, res, err, busy, mult_ld, mult_a, mult_b});
        end
        total++;
        if (state_dbg !== 2'd0) begin
            bad++; $display("FAIL reset_state got=%0d want=0", state_dbg);
        end
        reset = 1'b1;
        @(negedge clk);
        unused = '0;
    endtask

    task automatic test_contention();
        logic [7:0]    a, b;
        logic [15:0]   p[N];
        logic [EW-1:0] ex;
        logic [N-1:0]  reraise;
        int            n;
        int            order[5];
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            a = 8'h10 + 8'(i * 3);
            b = 8'h21 + 8'(i * 5);
            set_op(i, a, b);
            p[i] = {8'h00, a} * {8'h00, b};
        end
        for (int k = 0; k < 5; k++)
            exp_q.push_back({N'(1) << order[k], p[order[k]], 1'b0});
        mult_rand = 1'b1;
        reraise   = '0;
        n         = 0;
        req       = '1;
        for (int k = 0; k < 400 && n < 5; k++) begin
            @(negedge clk);
            if (reraise != '0) begin
                req     = req | reraise;
                reraise = '0;
            end
            if (done !== '0) begin
                ex = exp_q.pop_front();
                total++;
                if ({done, res, err} !== ex) begin
                    bad++; $display("FAIL contention_%0d got=%h want=%h", n, {done, res, err}, ex);
                end
                n++;
                req = req & ~done;
                if (n < 5) reraise = done;
                else req = '0;
            end
        end
        total++;
        if (n != 5) begin
            bad++; $display("FAIL contention_count got=%0d want=5", n);
        end
        mult_rand = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL contention_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_single();
        logic [N-1:0]  d;
        logic [15:0]   r;
        logic          e;
        int            at, t0;
        logic [EW-1:0] ex;
        mult_lat = 8;
        set_op(0, 8'h0F, 8'h11);
        exp_q.push_back({4'b0001, 16'h00FF, 1'b0});
        req = 4'b0001;
        t0  = cyc;
        @(negedge clk);
        total++;
        if ({mult_ld, gnt, busy} !== {1'b1, 4'b0001, 1'b1}) begin
            bad++; $display("FAIL single_load got=%b want=%b", {mult_ld, gnt, busy}, {1'b1, 4'b0001, 1'b1});
        end
        total++;
        if ({mult_a, mult_b} !== 16'h0F11) begin
            bad++; $display("FAIL single_operands got=%h want=0f11", {mult_a, mult_b});
        end
        set_op(0, 8'hAA, 8'hBB);   // late operand change must be ignored
        @(negedge clk);
        total++;
        if ({mult_ld, gnt} !== {1'b0, 4'b0001}) begin
            bad++; $display("FAIL single_ld_pulse got=%b want=%b", {mult_ld, gnt}, {1'b0, 4'b0001});
        end
        wait_done(40, d, r, e, at);
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL single_done got=%h want=%h", {d, r, e}, ex);
        end
        total++;
        if (at != t0 + 10) begin
            bad++; $display("FAIL single_latency got=%0d want=%0d", at - t0, 10);
        end
        @(negedge clk);
        total++;
        if ({done, busy, gnt} !== '0) begin
            bad++; $display("FAIL single_after got=%b want=0", {done, busy, gnt});
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]  d;
        logic [15:0]   r;
        logic          e;
        int            at1, at2, t0;
        logic [EW-1:0] ex;
        mult_lat = 1;
        set_op(2, 8'h0C, 8'h0D);
        exp_q.push_back({4'b0100, 16'h009C, 1'b0});
        exp_q.push_back({4'b0100, 16'h009C, 1'b0});
        req = 4'b0100;
        t0  = cyc;
        wait_done(20, d, r, e, at1);
        ex = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL b2b_first got=%h want=%h", {d, r, e}, ex);
        end
        total++;
        if (at1 != t0 + 3) begin
            bad++; $display("FAIL b2b_first_latency got=%0d want=3", at1 - t0);
        end
        wait_done(20, d, r, e, at2);   // req held high: re-arbitrated as a new request
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", {d, r, e}, ex);
        end
        total++;
        if (at2 != at1 + 4) begin
            bad++; $display("FAIL b2b_spacing got=%0d want=4", at2 - at1);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [N-1:0]  d;
        logic [15:0]   r;
        logic          e;
        int            at, t0;
        logic [EW-1:0] ex;
        mult_mute = 1'b1;
        set_op(1, 8'h12, 8'h34);
        exp_q.push_back({4'b0010, 16'h0000, 1'b1});
        req = 4'b0010;
        t0  = cyc;
        wait_done(TO + 20, d, r, e, at);
        req = '0;
        mult_mute = 1'b0;
        ex = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL timeout_done got=%h want=%h", {d, r, e}, ex);
        end
        total++;
        if (at != t0 + TO + 3) begin
            bad++; $display("FAIL timeout_latency got=%0d want=%0d", at - t0, TO + 3);
        end
        @(negedge clk);
        mult_lat = 2;
        set_op(1, 8'h03, 8'h05);
        exp_q.push_back({4'b0010, 16'h000F, 1'b0});
        req = 4'b0010;
        t0  = cyc;
        wait_done(20, d, r, e, at);
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL timeout_recover got=%h want=%h", {d, r, e}, ex);
        end
        total++;
        if (at != t0 + 4) begin
            bad++; $display("FAIL timeout_recover_latency got=%0d want=4", at - t0);
        end
        @(negedge clk);
    endtask

    task automatic test_race();
        logic [N-1:0]  d;
        logic [15:0]   r;
        logic          e;
        int            at, t0;
        logic [EW-1:0] ex;
        force_en  = 1'b1;
        force_val = 16'hFFFF;
        mult_lat  = TO + 1;          // ready lands in the cycle the counter equals TIMEOUT
        set_op(2, 8'h01, 8'h01);
        exp_q.push_back({4'b0100, 16'hFFFF, 1'b0});
        req = 4'b0100;
        t0  = cyc;
        wait_done(TO + 20, d, r, e, at);
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL race_done got=%h want=%h", {d, r, e}, ex);
        end
        total++;
        if (at != t0 + TO + 3) begin
            bad++; $display("FAIL race_latency got=%0d want=%0d", at - t0, TO + 3);
        end
        @(negedge clk);
        mult_lat = TO + 2;           // one cycle too late: times out, ready falls in DONE
        exp_q.push_back({4'b0100, 16'h0000, 1'b1});
        req = 4'b0100;
        t0  = cyc;
        wait_done(TO + 20, d, r, e, at);
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL late_rdy_done got=%h want=%h", {d, r, e}, ex);
        end
        total++;
        if (at != t0 + TO + 3) begin
            bad++; $display("FAIL late_rdy_latency got=%0d want=%0d", at - t0, TO + 3);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({done, busy} !== '0) begin
                bad++; $display("FAIL late_rdy_quiet got=%b want=0", {done, busy});
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_edges();
        logic [N-1:0]  d;
        logic [15:0]   r;
        logic          e;
        int            at;
        logic [EW-1:0] ex;
        mult_lat = $urandom_range(1, 5);
        set_op(3, 8'hFF, 8'hFF);
        exp_q.push_back({4'b1000, 16'hFE01, 1'b0});
        req = 4'b1000;
        wait_done(20, d, r, e, at);
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL edge_ffxff got=%h want=%h", {d, r, e}, ex);
        end
        @(negedge clk);
        mult_lat = $urandom_range(1, 5);
        set_op(0, 8'h00, 8'hAB);
        exp_q.push_back({4'b0001, 16'h0000, 1'b0});
        req = 4'b0001;
        wait_done(20, d, r, e, at);
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL edge_zero got=%h want=%h", {d, r, e}, ex);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0]  d;
        logic [15:0]   r;
        logic          e;
        int            at, r0;
        logic [EW-1:0] ex;
        bit            seen;
        mult_lat = 12;
        set_op(0, 8'h07, 8'h09);
        req = 4'b0001;
        @(negedge clk);
        req = '0;                    // withdrawing after the grant has no effect
        repeat (3) @(negedge clk);
        total++;
        if ({state_dbg, busy} !== {2'd2, 1'b1}) begin
            bad++; $display("FAIL mid_in_wait got=%b want=%b", {state_dbg, busy}, {2'd2, 1'b1});
        end
        r0 = rdy_seen;
        reset = 1'b0;
        #1;
        total++;
        if ({gnt, done, res, err, busy, mult_ld, mult_a, mult_b, state_dbg} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h want=0", {gnt, done, res, err, busy, mult_ld, mult_a, mult_b, state_dbg});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            total++;
            if ({done, busy} !== '0) begin
                bad++; $display("FAIL mid_no_done got=%b want=0", {done, busy});
            end
            if (rdy_seen > r0) seen = 1'b1;
        end
        repeat (2) @(negedge clk);
        total++;
        if ({done, busy} !== '0) begin
            bad++; $display("FAIL mid_late_rdy_ignored got=%b want=0", {done, busy});
        end
        mult_lat = 2;
        for (int i = 0; i < N; i++) set_op(i, 8'h20 + 8'(i), 8'h03);
        exp_q.push_back({4'b0001, 16'h0060, 1'b0});
        req = 4'b1111;
        wait_done(20, d, r, e, at);
        req = '0;
        ex  = exp_q.pop_front();
        total++;
        if ({d, r, e} !== ex) begin
            bad++; $display("FAIL mid_first_after_reset got=%h want=%h", {d, r, e}, ex);
        end
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL mid_final_idle got=%b want=0", busy);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_contention();
        test_single();
        test_back_to_back();
        test_timeout();
        test_race();
        test_edges();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer for the shared 8x8 sequential multiplier. Up to N_REQ requesters (colour generator, brightness scaler, future fade/gamma units) post operand pairs. The block grants one requester at a time, loads the multiplier, waits for its ready pulse and returns the 16-bit product. A watchdog timeout means a stalled multiplier cannot lock the lamp datapath.

## Interface
Parameters:
- N_REQ, 4: number of requesters (2..8).
- TIMEOUT, 63: maximum WAIT cycles before the operation is aborted with err.

Ports:
- clk  in  1  system clock; the block uses this single clock only.
- reset  in  1  reset, asynchronous and active-low.
- req  in  N_REQ  per-requester request level.
- op_a  in  8*N_REQ  packed multiplicand; requester i uses bits [8i+7:8i].
- op_b  in  8*N_REQ  packed multiplier; same packing as op_a.
- gnt  out  N_REQ  one-hot grant, high from LOAD through DONE.
- done  out  N_REQ  one-hot, single-cycle completion strobe.
- res  out  16  product; valid only in the done cycle.
- err  out  1  high with done when the operation timed out; res = 0 in that case.
- busy  out  1  high in any state other than IDLE.
- mult_ld  out  1  one-cycle load strobe to the multiplier.
- mult_a, mult_b  out  8  registered operands, held stable from LOAD through DONE.
- mult_rdy  in  1  single-cycle pulse from the multiplier; mult_result is valid in that cycle.
- mult_result  in  16  multiplier product.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - If req is non-zero, select the winner by round robin: search from index last+1 upward, wrapping modulo N_REQ.
  - Latch the winner index into idx and latch its op_a/op_b slices into mult_a/mult_b.
  - Go to LOAD. With no request, stay in IDLE.
- LOAD:
  - Assert mult_ld and gnt[idx].
  - Clear the timeout counter to 0.
  - Go to WAIT.
- WAIT:
  - If mult_rdy is high: capture mult_result into res, clear err, go to DONE.
  - Else if counter == TIMEOUT: set res = 0 and err = 1, go to DONE.
  - Else increment the counter.
  - If mult_rdy and the timeout condition occur in the same cycle, mult_rdy wins.
- DONE:
  - Pulse done[idx] and keep gnt[idx] high.
  - Set last = idx.
  - Go to IDLE. req is ignored during this cycle.
- The requester must drop req in its done cycle. If req is still high when the FSM returns to IDLE, it is treated as a new request and arbitrated normally; other pending requesters win first.
- Withdrawing req after the grant has no effect. The operation completes and done still pulses.
- Operand changes on op_a/op_b after the IDLE sample are ignored.
- mult_rdy outside WAIT is ignored.
- Round-robin fairness: a continuously requesting agent waits at most N_REQ-1 operations.
- Reset, asynchronous and effective immediately, including mid-operation:
  - FSM goes to IDLE; last = N_REQ-1, so requester 0 has first priority.
  - gnt, done, res, err, busy, mult_ld, mult_a, mult_b and the counter are all 0.
  - An in-flight operation is discarded with no done.

## Timing
- Cycle T: req sampled in IDLE.
- T+1: LOAD, mult_ld = 1, gnt and busy high.
- T+2 onward: WAIT.
- mult_rdy at cycle R ≥ T+2 gives done/res at R+1.
- Earliest back-to-back service: the next IDLE sample is at R+2, so minimum overhead is 3 cycles per operation beyond multiplier latency.
- Timeout: with no mult_rdy, done and err occur at T+2+TIMEOUT+1.
- All outputs are registered; there is no combinational path from req or mult_rdy to any output.

## Structure
- Shared package holds:
  - the state encoding (IDLE=0, LOAD=1, WAIT=2, DONE=3);
  - default N_REQ and TIMEOUT;
  - the counter width, $clog2(TIMEOUT+1).
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req, last.
  - Outputs: any, winner index.
  - Reusable by a future PWM or SPI arbiter.

## Test plan
- Single request: req=0001, op_a[0]=0x0F, op_b[0]=0x11, multiplier responds after 8 cycles -> mult_ld one pulse at T+1, done=0001 with res=0x00FF, err=0.
- Contention: all four req high held continuously, each dropping in its done cycle and re-raising next cycle -> grant order 0,1,2,3,0, with no grant repeated while another is pending.
- Timeout: req=0010, mult_rdy tied low -> done=0010, err=1, res=0 exactly TIMEOUT+3 cycles after the IDLE sample; the next request is served normally.
- Race: mult_rdy arrives in the same cycle the counter reaches TIMEOUT, with product 0xFFFF -> err=0, res=0xFFFF.
- Edge products: operands 0xFF×0xFF -> 0xFE01, and 0x00×0xAB -> 0x0000.
- Reset mid-WAIT: assert reset during WAIT -> all outputs 0 immediately; after release, the late mult_rdy is ignored; with req=1111, requester 0 is served first.
